// File: rtl/cmd_packet_receiver.sv
// ---------------------------------------------------------------------------
// cmd_packet_receiver
//
// Parses command packets from a 32-bit receive stream. Each packet is
// buffered until its XOR trailer has been checked. Only after that are the
// address/data pairs replayed as register writes, so a corrupt or truncated
// packet never reaches the register bus.
//
// Packet: word0 {MAGIC, seq[7:0], N[7:0]}, then N x {addr word, data word},
//         then a trailer equal to the XOR of every preceding word (eop here).
//
// Ports
//   sys_clk      in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   i_rx_data    in   32-bit receive word
//   i_rx_vld     in   beat valid
//   i_rx_sop     in   first beat of a packet
//   i_rx_eop     in   last beat of a packet
//   o_rx_rdy     out  beat accepted when i_rx_vld & o_rx_rdy (low while committing)
//   o_wr_addr    out  register write address
//   o_wr_data    out  register write data
//   o_wr_stb     out  one-cycle write strobe
//   o_cmd_done   out  one-cycle pulse after the last write of a packet
//   o_ok_cnt     out  committed packet count (wraps)
//   o_err_cnt    out  rejected packet count (wraps)
//   o_last_seq   out  sequence number of the last committed packet
//   o_err_code   out  last error (0 none, 1 magic, 2 count, 3 early eop,
//                     4 missing eop, 5 checksum, 6 sop mid-packet)
// ---------------------------------------------------------------------------
module cmd_packet_receiver #(
    parameter int unsigned MAX_PAIRS = 16,
    parameter logic [15:0] MAGIC     = 16'hC0DE
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_vld,
    input  logic        i_rx_sop,
    input  logic        i_rx_eop,
    output logic        o_rx_rdy,
    output logic [7:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_wr_stb,
    output logic        o_cmd_done,
    output logic [15:0] o_ok_cnt,
    output logic [15:0] o_err_cnt,
    output logic [7:0]  o_last_seq,
    output logic [2:0]  o_err_code
);

    localparam int unsigned AW    = (MAX_PAIRS > 1) ? $clog2(MAX_PAIRS) : 1;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned IW    = AW + 1;   // index must reach MAX_PAIRS itself

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_DRAIN,
        S_COMMIT
    } state_t;

    typedef enum logic [2:0] {
        E_NONE      = 3'd0,
        E_MAGIC     = 3'd1,
        E_COUNT     = 3'd2,
        E_EARLY_EOP = 3'd3,
        E_NO_EOP    = 3'd4,
        E_CSUM      = 3'd5,
        E_SOP       = 3'd6
    } err_t;

    state_t          state_q;
    logic            rdy_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   npairs_q;
    logic [7:0]      seq_q;
    logic [31:0]     csum_q;
    logic [7:0]      wr_addr_q;
    logic [31:0]     wr_data_q;
    logic            wr_stb_q;
    logic            done_q;
    logic [15:0]     ok_cnt_q;
    logic [15:0]     err_cnt_q;
    logic [7:0]      last_seq_q;
    err_t            err_code_q;

    logic [7:0]      addr_mem [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic            accept;
    logic            in_pkt;
    logic [7:0]      hdr_n;
    err_t            hdr_err;
    logic [IW-1:0]   idx_inc;
    logic            addr_we;
    logic            data_we;
    logic [1:0]      err_inc_d;
    err_t            err_code_d;

    assign accept  = i_rx_vld & rdy_q;
    assign in_pkt  = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign hdr_n   = i_rx_data[7:0];
    assign idx_inc = idx_q + IW'(1);
    assign addr_we = accept & ~i_rx_sop & ~i_rx_eop & (state_q == S_ADDR);
    assign data_we = accept & ~i_rx_sop & ~i_rx_eop & (state_q == S_DATA);

    always_comb begin
        hdr_err = E_NONE;
        if (i_rx_data[31:16] != MAGIC) begin
            hdr_err = E_MAGIC;
        end else if ((hdr_n == 8'd0) || (32'(hdr_n) > MAX_PAIRS)) begin
            hdr_err = E_COUNT;
        end
    end

    // A sop beat inside a packet aborts that packet (one error) and is then
    // reparsed as a header, which may itself be rejected (a second error).
    always_comb begin
        err_inc_d  = '0;
        err_code_d = err_code_q;
        if (accept) begin
            if (i_rx_sop) begin
                if (in_pkt) begin
                    err_inc_d  = 2'd1;
                    err_code_d = E_SOP;
                end
                if (hdr_err != E_NONE) begin
                    err_inc_d  = err_inc_d + 2'd1;
                    err_code_d = hdr_err;
                end else if (i_rx_eop) begin
                    // Valid header that already ends the packet has no pairs.
                    err_inc_d  = err_inc_d + 2'd1;
                    err_code_d = E_EARLY_EOP;
                end
            end else begin
                case (state_q)
                    S_ADDR, S_DATA: begin
                        if (i_rx_eop) begin
                            err_inc_d  = 2'd1;
                            err_code_d = E_EARLY_EOP;
                        end
                    end
                    S_CSUM: begin
                        if (i_rx_data != csum_q) begin
                            err_inc_d  = 2'd1;
                            err_code_d = E_CSUM;
                        end else if (!i_rx_eop) begin
                            err_inc_d  = 2'd1;
                            err_code_d = E_NO_EOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pair buffer: written only while parsing, read only while committing.
    always_ff @(posedge sys_clk) begin
        if (addr_we) addr_mem[idx_q[AW-1:0]] <= i_rx_data[7:0];
        if (data_we) data_mem[idx_q[AW-1:0]] <= i_rx_data;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rdy_q      <= 1'b0;
            idx_q      <= '0;
            npairs_q   <= '0;
            seq_q      <= '0;
            csum_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_stb_q   <= 1'b0;
            done_q     <= 1'b0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            last_seq_q <= '0;
            err_code_q <= E_NONE;
        end else begin
            wr_stb_q   <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b1;
            err_cnt_q  <= err_cnt_q + 16'(err_inc_d);
            err_code_q <= err_code_d;

            if (state_q == S_COMMIT) begin
                if (idx_q == npairs_q) begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                end else begin
                    rdy_q     <= 1'b0;
                    wr_addr_q <= addr_mem[idx_q[AW-1:0]];
                    wr_data_q <= data_mem[idx_q[AW-1:0]];
                    wr_stb_q  <= 1'b1;
                    idx_q     <= idx_inc;
                end
            end else if (accept) begin
                if (i_rx_sop) begin
                    if (hdr_err != E_NONE) begin
                        state_q <= i_rx_eop ? S_IDLE : S_DRAIN;
                    end else if (i_rx_eop) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q  <= S_ADDR;
                        seq_q    <= i_rx_data[15:8];
                        npairs_q <= i_rx_data[IW-1:0];
                        csum_q   <= i_rx_data;
                        idx_q    <= '0;
                    end
                end else begin
                    case (state_q)
                        S_ADDR: begin
                            if (i_rx_eop) begin
                                state_q <= S_IDLE;
                            end else begin
                                csum_q  <= csum_q ^ i_rx_data;
                                state_q <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            if (i_rx_eop) begin
                                state_q <= S_IDLE;
                            end else begin
                                csum_q  <= csum_q ^ i_rx_data;
                                idx_q   <= idx_inc;
                                state_q <= (idx_inc == npairs_q) ? S_CSUM : S_ADDR;
                            end
                        end
                        S_CSUM: begin
                            if (!i_rx_eop) begin
                                state_q <= S_DRAIN;
                            end else if (i_rx_data == csum_q) begin
                                state_q    <= S_COMMIT;
                                rdy_q      <= 1'b0;
                                idx_q      <= '0;
                                ok_cnt_q   <= ok_cnt_q + 16'd1;
                                last_seq_q <= seq_q;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                        S_DRAIN: begin
                            if (i_rx_eop) state_q <= S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_rx_rdy   = rdy_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_wr_stb   = wr_stb_q;
    assign o_cmd_done = done_q;
    assign o_ok_cnt   = ok_cnt_q;
    assign o_err_cnt  = err_cnt_q;
    assign o_last_seq = last_seq_q;
    assign o_err_code = err_code_q;

endmodule
